// File: rtl/da_stream_unpack_if.sv
// FIFO read port of the DA stream unpacker: FWFT head word, empty flag, pop.
interface da_stream_unpack_if #(
    parameter int DIN_W = 128
);
    logic             rd_en;
    logic [DIN_W-1:0] din;
    logic             empty;

    modport master (
        output din,
        output empty,
        input  rd_en
    );

    modport slave (
        input  din,
        input  empty,
        output rd_en
    );
endinterface

// File: rtl/da_stream_unpack.sv
// Pops packed words from a FWFT FIFO and plays them out lane by lane,
// MSB lane first, as NCH registered DA codes with per-lane hold.
module da_stream_unpack #(
    parameter int DIN_W     = 128,
    parameter int LANE_W    = 16,
    parameter int NCH       = 2,
    parameter int DA_W      = 6,
    parameter int CH_STRIDE = 8,
    parameter int HOLD_W    = 8,
    parameter int UCNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                enable,
    input  logic [HOLD_W-1:0]   hold_cycles,
    da_stream_unpack_if.slave   fifo,
    output logic [NCH*DA_W-1:0] da,
    output logic                da_valid,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_cnt,
    output logic                busy
);
    localparam int LANES  = DIN_W / LANE_W;
    localparam int LIDX_W = $clog2(LANES);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [DIN_W-1:0]  sreg;
    logic [LIDX_W-1:0] lane_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_lat;
    logic              last_slot;
    logic              load;

    function automatic logic [NCH*DA_W-1:0] fields(
        input logic [LANE_W-1:0] ln
    );
        logic [NCH*DA_W-1:0] f;
        f = '0;
        for (int c = 0; c < NCH; c++)
            f[c*DA_W +: DA_W] = ln[LANE_W-1-c*CH_STRIDE -: DA_W];
        return f;
    endfunction

    assign last_slot = (state == RUN)
                    && (lane_idx == LIDX_W'(LANES - 1))
                    && (hold_cnt == hold_lat);

    assign load = !RST && enable && !fifo.empty
               && ((state == IDLE) || last_slot);

    assign fifo.rd_en = load;
    assign busy       = (state == RUN);

    // The shown lane always sits at the top of sreg; advancing shifts left.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            sreg         <= '0;
            lane_idx     <= '0;
            hold_cnt     <= '0;
            hold_lat     <= '0;
            da           <= '0;
            da_valid     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            if (load) begin
                sreg     <= fifo.din;
                da       <= fields(fifo.din[DIN_W-1 -: LANE_W]);
                da_valid <= 1'b1;
                state    <= RUN;
                hold_cnt <= '0;
                lane_idx <= '0;
                hold_lat <= hold_cycles;
            end else if (last_slot) begin
                state    <= IDLE;
                da_valid <= 1'b0;
                if (enable) begin
                    underrun <= 1'b1;
                    if (underrun_cnt != '1)
                        underrun_cnt <= underrun_cnt + UCNT_W'(1);
                end
            end else if (state == RUN) begin
                if (hold_cnt < hold_lat) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end else begin
                    hold_cnt <= '0;
                    lane_idx <= lane_idx + LIDX_W'(1);
                    sreg     <= sreg << LANE_W;
                    da       <= fields(sreg[DIN_W-1-LANE_W -: LANE_W]);
                end
            end
        end
    end
endmodule
